button_conditioner: RTL and testbench

Input front end for the game board: takes the three raw push-buttons, synchronises and debounces each one, and hands the game/VGA logic clean move levels plus a sticky fire request. The fire request stays up until it is acknowledged, so the slow game tick cannot miss a press. It also keeps a saturating count of accepted shots, which the seven-segment display shows.

---
 rtl/button_conditioner_pkg.sv | 26 ++
 rtl/button_conditioner_if.sv | 42 ++++
 rtl/button_conditioner_debounce_fsm.sv | 113 +++++++++++
 rtl/button_conditioner.sv | 142 ++++++++++++++
 tb/tb_button_conditioner.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// button_conditioner_pkg
//   Shared definitions for the game-board button front end: the per-button
//   debounce state encoding, default timing constants for a 50 MHz board
//   clock, and the width of the shot counter shown on the seven-segment
//   display.
// ----------------------------------------------------------------------------
package button_conditioner_pkg;

    // Debounce FSM states: two stable levels and two "candidate change" states
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } dbState_e;

    // 10 ms of stable input at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;

    // 250 ms auto-repeat interval at 50 MHz
    localparam int unsigned REPEAT_CYCLES_DEF = 12500000;

    localparam int unsigned SHOT_COUNT_W = 8;

endpackage

// File: rtl/button_conditioner_if.sv
// ----------------------------------------------------------------------------
// button_conditioner_if
//   Bundle of the board-facing and game-facing signals of the button front end.
//   Signals:
//     btn_l_raw/btn_r_raw/btn_u_raw : raw asynchronous push-buttons
//     fire_ack                      : one-cycle pulse consuming a fire request
//     btn_l_db/btn_r_db/btn_u_db    : debounced button levels
//     move_left/move_right          : registered move commands
//     fire_req                      : sticky fire request
//     shot_count                    : saturating count of acknowledged shots
//   Modports:
//     slave  : the conditioner itself (consumes raw buttons and ack)
//     master : the surrounding board/game logic
// ----------------------------------------------------------------------------
interface button_conditioner_if;
    import button_conditioner_pkg::*;

    logic                    btn_l_raw;
    logic                    btn_r_raw;
    logic                    btn_u_raw;
    logic                    fire_ack;
    logic                    btn_l_db;
    logic                    btn_r_db;
    logic                    btn_u_db;
    logic                    move_left;
    logic                    move_right;
    logic                    fire_req;
    logic [SHOT_COUNT_W-1:0] shot_count;

    modport slave (
        input  btn_l_raw, btn_r_raw, btn_u_raw, fire_ack,
        output btn_l_db, btn_r_db, btn_u_db,
        output move_left, move_right, fire_req, shot_count
    );

    modport master (
        output btn_l_raw, btn_r_raw, btn_u_raw, fire_ack,
        input  btn_l_db, btn_r_db, btn_u_db,
        input  move_left, move_right, fire_req, shot_count
    );

endinterface

// File: rtl/button_conditioner_debounce_fsm.sv
// ----------------------------------------------------------------------------
// debounce_fsm
//   Two-flop synchroniser followed by a four-state debounce FSM for a single
//   push-button. The debounced level only changes after DEBOUNCE_CYCLES
//   consecutive synchronised samples at the new level; any sample at the old
//   level during the wait drops back to the stable state.
//   Parameters:
//     DEBOUNCE_CYCLES : stable samples required for a level change (>= 2)
//   Ports:
//     board_clk : system clock
//     reset     : asynchronous, active-high
//     raw_i     : raw, asynchronous, bouncing button input
//     db_o      : debounced level
// ----------------------------------------------------------------------------
module debounce_fsm
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic board_clk,
    input  logic reset,
    input  logic raw_i,
    output logic db_o
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_badDebounce
        $error("debounce_fsm: DEBOUNCE_CYCLES must be >= 2");
    end

    logic             sync1_q;
    logic             sync2_q;
    dbState_e         state_q;
    dbState_e         state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Metastability guard: raw button is only ever looked at through sync2_q
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // State and stability counter registers
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE_LO;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Entering a WAIT state already counts the first sample at the new level,
    // so the count starts at 1 and the level flips on the sample where it
    // reaches DEBOUNCE_CYCLES-1.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE_LO: begin
                if (sync2_q) begin
                    state_d = WAIT_HI;
                    count_d = CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (!sync2_q) begin
                    state_d = IDLE_LO;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            IDLE_HI: begin
                if (!sync2_q) begin
                    state_d = WAIT_LO;
                    count_d = CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (sync2_q) begin
                    state_d = IDLE_HI;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LO;
                count_d = '0;
            end
        endcase
    end

    // The debounced level is a pure decode of the registered state
    assign db_o = (state_q == IDLE_HI) || (state_q == WAIT_LO);

endmodule

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
//   Game-board input front end. Debounces the left/right/up buttons, produces
//   registered move commands, a sticky fire request held until the game logic
//   acknowledges it, and a saturating count of acknowledged shots.
//   Optional feature macro: FIRE_AUTOREPEAT_EN -- when defined, holding the
//   fire button re-raises fire_req every REPEAT_CYCLES cycles after each ack.
//   Parameters:
//     DEBOUNCE_CYCLES : stable samples required for a debounced change (>= 2)
//     REPEAT_CYCLES   : auto-repeat interval in board_clk cycles (>= 2)
//   Ports:
//     board_clk : system clock, 50 MHz
//     reset     : asynchronous, active-high
//     bus       : button_conditioner_if.slave (raw buttons, ack, all outputs)
// ----------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic                  board_clk,
    input  logic                  reset,
    button_conditioner_if.slave   bus
);

    if (REPEAT_CYCLES < 2) begin : g_badRepeat
        $error("button_conditioner: REPEAT_CYCLES must be >= 2");
    end

    logic                    btnLDb;
    logic                    btnRDb;
    logic                    btnUDb;
    logic                    moveLeft_q;
    logic                    moveRight_q;
    logic                    uDelay_q;
    logic                    uRise_q;
    logic                    fireReq_q;
    logic                    fireReq_d;
    logic [SHOT_COUNT_W-1:0] shotCount_q;
    logic [SHOT_COUNT_W-1:0] shotCount_d;
    logic                    repeatFire;

    debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbLeft (
        .board_clk (board_clk),
        .reset     (reset),
        .raw_i     (bus.btn_l_raw),
        .db_o      (btnLDb)
    );

    debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbRight (
        .board_clk (board_clk),
        .reset     (reset),
        .raw_i     (bus.btn_r_raw),
        .db_o      (btnRDb)
    );

    debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbUp (
        .board_clk (board_clk),
        .reset     (reset),
        .raw_i     (bus.btn_u_raw),
        .db_o      (btnUDb)
    );

`ifdef FIRE_AUTOREPEAT_EN
    localparam int unsigned      RPT_W    = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] repeat_q;
    logic [RPT_W-1:0] repeat_d;

    // Repeat timer only runs while fire is held and nothing is pending, so
    // every interval is measured from the ack that consumed the last request
    always_comb begin
        repeat_d   = repeat_q;
        repeatFire = 1'b0;
        if (!btnUDb || fireReq_q) begin
            repeat_d = '0;
        end else if (repeat_q == RPT_LAST) begin
            repeat_d   = '0;
            repeatFire = 1'b1;
        end else begin
            repeat_d = repeat_q + 1'b1;
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            repeat_q <= '0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
`else
    assign repeatFire = 1'b0;
`endif

    // Set has priority over the ack so a press landing on the ack edge is
    // never lost; an extra press while pending just merges into the request
    always_comb begin
        fireReq_d   = fireReq_q;
        shotCount_d = shotCount_q;
        if (bus.fire_ack) begin
            fireReq_d = 1'b0;
        end
        if (uRise_q || repeatFire) begin
            fireReq_d = 1'b1;
        end
        if (bus.fire_ack && fireReq_q && (shotCount_q != '1)) begin
            shotCount_d = shotCount_q + 1'b1;
        end
    end

    // Move commands are suppressed on conflicting directions or while firing;
    // the fire rise is registered so fire_req lands two edges after btn_u_db
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            moveLeft_q  <= 1'b0;
            moveRight_q <= 1'b0;
            uDelay_q    <= 1'b0;
            uRise_q     <= 1'b0;
            fireReq_q   <= 1'b0;
            shotCount_q <= '0;
        end else begin
            moveLeft_q  <= btnLDb & ~btnRDb & ~btnUDb;
            moveRight_q <= btnRDb & ~btnLDb & ~btnUDb;
            uDelay_q    <= btnUDb;
            uRise_q     <= btnUDb & ~uDelay_q;
            fireReq_q   <= fireReq_d;
            shotCount_q <= shotCount_d;
        end
    end

    assign bus.btn_l_db   = btnLDb;
    assign bus.btn_r_db   = btnRDb;
    assign bus.btn_u_db   = btnUDb;
    assign bus.move_left  = moveLeft_q;
    assign bus.move_right = moveRight_q;
    assign bus.fire_req   = fireReq_q;
    assign bus.shot_count = shotCount_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 and
//   REPEAT_CYCLES=8. Inputs change on the falling edge; outputs are sampled on
//   the falling edge after the rising edge of interest.
// ----------------------------------------------------------------------------
module tb_button_conditioner;

    logic board_clk;
    logic reset;
    int   checkCount;
    int   passCount;
    int   timeouts;

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .board_clk (board_clk),
        .reset     (reset),
        .bus       (bif.slave)
    );

    // 10-unit clock period
    initial begin
        board_clk = 1'b0;
        forever #5 board_clk = ~board_clk;
    end

    // Hard stop if the directed sequence ever stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Wait n rising edges, then settle on the following falling edge
    task automatic stepTo(input int n);
        repeat (n) @(posedge board_clk);
        @(negedge board_clk);
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic u, input logic ack);
        bif.btn_l_raw = l;
        bif.btn_r_raw = r;
        bif.btn_u_raw = u;
        bif.fire_ack  = ack;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else begin
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // Single-cycle ack on the next rising edge, leaving raw buttons as given
    task automatic pulseAck(input logic l, input logic r, input logic u);
        applyStimulus(l, r, u, 1'b1);
        stepTo(1);
        applyStimulus(l, r, u, 1'b0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        timeouts   = 0;
        reset      = 1'b1;
        applyStimulus(0, 0, 0, 0);
        stepTo(2);
        checkOutput("rst_fire_req", 8'(bif.fire_req), 8'd0);
        checkOutput("rst_shot", bif.shot_count, 8'd0);
        checkOutput("rst_moves", 8'({bif.move_left, bif.move_right}), 8'd0);
        checkOutput("rst_dbs", 8'({bif.btn_l_db, bif.btn_r_db, bif.btn_u_db}), 8'd0);
        reset = 1'b0;
        stepTo(2);

        // Ack with nothing pending is ignored
        pulseAck(0, 0, 0);
        checkOutput("idle_ack_shot", bif.shot_count, 8'd0);
        checkOutput("idle_ack_fire", 8'(bif.fire_req), 8'd0);

        // Clean press: db on edge 5, fire_req on edge 7
        applyStimulus(0, 0, 1, 0);
        stepTo(5);
        checkOutput("clean_db_e4", 8'(bif.btn_u_db), 8'd0);
        stepTo(1);
        checkOutput("clean_db_e5", 8'(bif.btn_u_db), 8'd1);
        stepTo(1);
        checkOutput("clean_fire_e6", 8'(bif.fire_req), 8'd0);
        stepTo(1);
        checkOutput("clean_fire_e7", 8'(bif.fire_req), 8'd1);
        checkOutput("fire_blocks_move", 8'({bif.move_left, bif.move_right}), 8'd0);
        pulseAck(0, 0, 1);
        checkOutput("clean_ack_fire", 8'(bif.fire_req), 8'd0);
        checkOutput("clean_ack_shot", bif.shot_count, 8'd1);
        applyStimulus(0, 0, 0, 0);
        stepTo(8);
        checkOutput("clean_release_db", 8'(bif.btn_u_db), 8'd0);

        // Rise coinciding with ack while a request is pending: set wins
        applyStimulus(0, 0, 1, 0);
        stepTo(8);
        checkOutput("simul_first_req", 8'(bif.fire_req), 8'd1);
        applyStimulus(0, 0, 0, 0);
        stepTo(8);
        checkOutput("simul_pending_hold", 8'(bif.fire_req), 8'd1);
        applyStimulus(0, 0, 1, 0);
        stepTo(7);
        pulseAck(0, 0, 1);
        checkOutput("simul_fire_stays", 8'(bif.fire_req), 8'd1);
        checkOutput("simul_shot", bif.shot_count, 8'd2);
        pulseAck(0, 0, 1);
        checkOutput("simul_second_ack_fire", 8'(bif.fire_req), 8'd0);
        checkOutput("simul_second_ack_shot", bif.shot_count, 8'd3);
        applyStimulus(0, 0, 0, 0);
        stepTo(8);

        // Bounce on left: samples 1,1,0 then steady 1 from edge 3
        applyStimulus(1, 0, 0, 0);
        stepTo(0);
        @(negedge board_clk);
        applyStimulus(1, 0, 0, 0);
        @(negedge board_clk);
        applyStimulus(0, 0, 0, 0);
        @(negedge board_clk);
        applyStimulus(1, 0, 0, 0);
        stepTo(5);
        checkOutput("bounce_db_e7", 8'(bif.btn_l_db), 8'd0);
        stepTo(1);
        checkOutput("bounce_db_e8", 8'(bif.btn_l_db), 8'd1);
        checkOutput("bounce_move_e8", 8'(bif.move_left), 8'd0);
        stepTo(1);
        checkOutput("bounce_move_e9", 8'(bif.move_left), 8'd1);

        // Conflict: right joins a held left
        applyStimulus(1, 1, 0, 0);
        stepTo(6);
        checkOutput("conflict_db_r", 8'(bif.btn_r_db), 8'd1);
        checkOutput("conflict_move_lag", 8'(bif.move_left), 8'd1);
        stepTo(1);
        checkOutput("conflict_moves", 8'({bif.move_left, bif.move_right}), 8'd0);
        applyStimulus(1, 0, 0, 0);
        stepTo(6);
        checkOutput("conflict_release_db_r", 8'(bif.btn_r_db), 8'd0);
        stepTo(1);
        checkOutput("conflict_left_back", 8'({bif.move_left, bif.move_right}), 8'd2);
        applyStimulus(0, 0, 0, 0);
        stepTo(8);
        checkOutput("left_release_move", 8'(bif.move_left), 8'd0);

        // Saturation: 300 press/ack rounds
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 0, 1, 0);
            for (int k = 0; k < 12; k++) begin
                if (bif.fire_req) break;
                stepTo(1);
            end
            if (!bif.fire_req) timeouts = timeouts + 1;
            pulseAck(0, 0, 1);
            applyStimulus(0, 0, 0, 0);
            stepTo(7);
        end
        checkOutput("sat_timeouts", 8'(timeouts), 8'd0);
        checkOutput("sat_shot", bif.shot_count, 8'd255);
        checkOutput("sat_fire", 8'(bif.fire_req), 8'd0);
        pulseAck(0, 0, 0);
        checkOutput("sat_spurious_shot", bif.shot_count, 8'd255);
        checkOutput("sat_spurious_fire", 8'(bif.fire_req), 8'd0);

        // Held fire after an ack: repeat only with the feature built in
        applyStimulus(0, 0, 1, 0);
        stepTo(8);
        checkOutput("hold_first_req", 8'(bif.fire_req), 8'd1);
        pulseAck(0, 0, 1);
        checkOutput("hold_ack_fire", 8'(bif.fire_req), 8'd0);
`ifdef FIRE_AUTOREPEAT_EN
        stepTo(7);
        checkOutput("repeat_before", 8'(bif.fire_req), 8'd0);
        stepTo(1);
        checkOutput("repeat_req", 8'(bif.fire_req), 8'd1);
`else
        stepTo(20);
        checkOutput("no_repeat", 8'(bif.fire_req), 8'd0);
`endif

        // Get fire_req=1 with left mid-debounce, then reset asynchronously
        applyStimulus(0, 0, 0, 0);
        stepTo(8);
        applyStimulus(0, 0, 1, 0);
        stepTo(8);
        checkOutput("pre_reset_fire", 8'(bif.fire_req), 8'd1);
        applyStimulus(1, 0, 1, 0);
        stepTo(4);
        reset = 1'b1;
        #1;
        checkOutput("async_rst_fire", 8'(bif.fire_req), 8'd0);
        checkOutput("async_rst_shot", bif.shot_count, 8'd0);
        checkOutput("async_rst_db_u", 8'(bif.btn_u_db), 8'd0);
        checkOutput("async_rst_moves", 8'({bif.move_left, bif.move_right}), 8'd0);
        stepTo(2);
        reset = 1'b0;
        stepTo(5);
        checkOutput("post_rst_db_l_e4", 8'(bif.btn_l_db), 8'd0);
        stepTo(1);
        checkOutput("post_rst_db_e5", 8'({bif.btn_l_db, bif.btn_u_db}), 8'd3);
        stepTo(2);
        checkOutput("post_rst_fire_e7", 8'(bif.fire_req), 8'd1);
        checkOutput("post_rst_shot", bif.shot_count, 8'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
